// File: rtl/prom_arbiter.sv
// prom_arbiter: shares a 1-cycle synchronous program ROM between fetch and data ports; PROM_ARB_STARVE_EN enables the data-port starvation guard.
module prom_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  output logic              data_gnt,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_data,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_dout
);
  typedef enum logic [1:0] {NONE, FETCH, DATA} owner_t;
  owner_t owner, owner_nx;
  logic starve;
  logic [ADDR_W-1:0] last_ad;
  logic [DATA_W-1:0] fetch_hold, data_hold;
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("STARVE_LIMIT out of range");
  end
`ifdef PROM_ARB_STARVE_EN
  logic [7:0] starve_cnt;
  assign starve = starve_cnt == 8'(STARVE_LIMIT);
  always_ff @(posedge clk)
    if (reset || !data_req || data_gnt) starve_cnt <= '0;
    else if (!starve) starve_cnt <= starve_cnt + 8'd1;
`else
  assign starve = 1'b0;
`endif
  assign rom_oce   = 1'b1;
  assign rom_reset = reset;
  always_comb begin
    data_gnt    = !reset && data_req && (!fetch_req || starve);
    fetch_gnt   = !reset && fetch_req && !data_gnt;
    rom_ce      = fetch_gnt || data_gnt;
    rom_ad      = fetch_gnt ? fetch_addr : data_gnt ? data_addr : last_ad;
    owner_nx    = fetch_gnt ? FETCH : data_gnt ? DATA : NONE;
    fetch_valid = !reset && owner == FETCH;
    data_valid  = !reset && owner == DATA;
    fetch_data  = fetch_valid ? rom_dout : fetch_hold;
    data_data   = data_valid ? rom_dout : data_hold;
  end
  always_ff @(posedge clk)
    if (reset) begin
      owner      <= NONE;
      last_ad    <= '0;
      fetch_hold <= '0;
      data_hold  <= '0;
    end else begin
      owner   <= owner_nx;
      last_ad <= rom_ad;
      if (fetch_valid) fetch_hold <= rom_dout;
      if (data_valid) data_hold <= rom_dout;
    end
endmodule

// File: tb/tb_prom_arbiter.sv
// tb_prom_arbiter: directed checks of prom_arbiter against a behavioural synchronous ROM.
module tb_prom_arbiter;
  logic clk = 0, reset = 1;
  logic fetch_req = 0, data_req = 0;
  logic [12:0] fetch_addr = '0, data_addr = '0, rom_ad;
  logic fetch_gnt, fetch_valid, data_gnt, data_valid, rom_ce, rom_oce, rom_reset;
  logic [15:0] fetch_data, data_data, rom_dout = '0;
  int checks = 0, errors = 0;

  prom_arbiter dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .data_req(data_req), .data_addr(data_addr), .data_gnt(data_gnt),
    .data_valid(data_valid), .data_data(data_data),
    .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_reset(rom_reset),
    .rom_ad(rom_ad), .rom_dout(rom_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [12:0] a);
    return {a, 3'b101} ^ 16'hC3A5;
  endfunction

  always @(posedge clk) if (rom_ce) rom_dout <= rom_word(rom_ad);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_fgnt", 32'(fetch_gnt), 0);
    chk("rst_dgnt", 32'(data_gnt), 0);
    chk("rst_fvalid", 32'(fetch_valid), 0);
    chk("rst_dvalid", 32'(data_valid), 0);
    chk("rst_fdata", 32'(fetch_data), 0);
    chk("rst_ddata", 32'(data_data), 0);
    chk("rst_ce", 32'(rom_ce), 0);
    chk("rst_ad", 32'(rom_ad), 0);
    chk("rst_oce", 32'(rom_oce), 1);
    chk("rst_romreset", 32'(rom_reset), 1);
    reset = 0;
    fetch_req = 1;
    fetch_addr = 13'h0000;
    #1;
    chk("f1_gnt", 32'(fetch_gnt), 1);
    chk("f1_ce", 32'(rom_ce), 1);
    chk("f1_dgnt", 32'(data_gnt), 0);
    chk("f1_ad", 32'(rom_ad), 0);
    chk("f1_romreset", 32'(rom_reset), 0);
    cyc();
    fetch_req = 0;
    #1;
    chk("f1_valid", 32'(fetch_valid), 1);
    chk("f1_data", 32'(fetch_data), 32'(rom_word(13'h0)));
    chk("f1_dvalid", 32'(data_valid), 0);
    chk("f1_idle_ce", 32'(rom_ce), 0);
    cyc();
    chk("f1_novalid", 32'(fetch_valid), 0);
    chk("f1_hold", 32'(fetch_data), 32'(rom_word(13'h0)));
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1;
      fetch_addr = 13'(i);
      #1;
      chk("stream_gnt", 32'(fetch_gnt), 1);
      if (i > 0) begin
        chk("stream_valid", 32'(fetch_valid), 1);
        chk("stream_data", 32'(fetch_data), 32'(rom_word(13'(i - 1))));
      end
      cyc();
    end
    fetch_req = 0;
    #1;
    chk("stream_valid_last", 32'(fetch_valid), 1);
    chk("stream_data_last", 32'(fetch_data), 32'(rom_word(13'h3)));
    cyc();
    fetch_req = 1;
    fetch_addr = 13'h0040;
    data_req = 1;
    data_addr = 13'h0100;
    for (int k = 1; k <= 9; k++) begin
      #1;
`ifdef PROM_ARB_STARVE_EN
      chk("starve_dgnt", 32'(data_gnt), 32'(k == 9));
      chk("starve_fgnt", 32'(fetch_gnt), 32'(k != 9));
`else
      chk("strict_dgnt", 32'(data_gnt), 0);
      chk("strict_fgnt", 32'(fetch_gnt), 1);
`endif
      cyc();
    end
`ifdef PROM_ARB_STARVE_EN
    #1;
    chk("starve_dvalid", 32'(data_valid), 1);
    chk("starve_ddata", 32'(data_data), 32'(rom_word(13'h100)));
    chk("starve_cleared_fgnt", 32'(fetch_gnt), 1);
    chk("starve_cleared_dgnt", 32'(data_gnt), 0);
    cyc();
    fetch_req = 0;
    data_req = 0;
    cyc();
`else
    fetch_req = 0;
    #1;
    chk("strict_drop_dgnt", 32'(data_gnt), 1);
    chk("strict_drop_ad", 32'(rom_ad), 32'h100);
    chk("strict_fvalid", 32'(fetch_valid), 1);
    cyc();
    data_req = 0;
    #1;
    chk("strict_dvalid", 32'(data_valid), 1);
    chk("strict_ddata", 32'(data_data), 32'(rom_word(13'h100)));
    cyc();
`endif
    data_req = 1;
    data_addr = 13'h0020;
    #1;
    chk("rstflt_dgnt", 32'(data_gnt), 1);
    cyc();
    data_req = 0;
    reset = 1;
    #1;
    chk("rstflt_dvalid_n1", 32'(data_valid), 0);
    chk("rstflt_ce_n1", 32'(rom_ce), 0);
    cyc();
    reset = 0;
    #1;
    chk("rstflt_dvalid_n2", 32'(data_valid), 0);
    chk("rstflt_ddata", 32'(data_data), 0);
    chk("rstflt_ce", 32'(rom_ce), 0);
    chk("rstflt_ad", 32'(rom_ad), 0);
    for (int k = 0; k < 5; k++) begin
      fetch_req = (k < 4) && (k % 2 == 0);
      data_req = (k < 4) && (k % 2 == 1);
      fetch_addr = 13'h0010;
      data_addr = 13'h0020;
      #1;
      chk("alt_both_valid", 32'(fetch_valid & data_valid), 0);
      if (k > 0) begin
        chk("alt_fvalid", 32'(fetch_valid), 32'(k % 2 == 1));
        chk("alt_dvalid", 32'(data_valid), 32'(k % 2 == 0));
        chk("alt_fdata", 32'(fetch_data), 32'(rom_word(13'h10)));
        if (k % 2 == 0) chk("alt_ddata", 32'(data_data), 32'(rom_word(13'h20)));
      end
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
